led_panel_sequencer: RTL and testbench

LED_PANEL_SEQUENCER -- requirements
Module: led_panel_sequencer

---
 rtl/led_panel_sequencer_pkg.sv | 16 +
 rtl/led_panel_sequencer_if.sv | 27 ++
 rtl/led_panel_sequencer_pwm.sv | 38 +++
 rtl/led_panel_sequencer.sv | 130 +++++++++++++
 tb/tb_led_panel_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_panel_sequencer_pkg.sv
// Shared types and widths for the LED panel sequencer slice.
// FSM state enum plus frame and PWM data widths.
package led_panel_pkg;

    localparam int FRAME_W = 32;
    localparam int PWM_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_HI,
        LATCH_LO
    } seq_state_t;

endpackage

// File: rtl/led_panel_sequencer_if.sv
// Frame request, brightness and LED chain pins of the sequencer.
// master = frame requester / board side, slave = sequencer.
interface led_panel_sequencer_if;
    import led_panel_pkg::*;

    logic [FRAME_W-1:0] frame_data;
    logic               frame_valid;
    logic               frame_ready;
    logic [PWM_W-1:0]   brightness;
    logic               DS;
    logic               SHCP;
    logic               STCP;
    logic               OE;
    logic               busy;
    logic               done;

    modport master (
        output frame_data, frame_valid, brightness,
        input  frame_ready, DS, SHCP, STCP, OE, busy, done
    );

    modport slave (
        input  frame_data, frame_valid, brightness,
        output frame_ready, DS, SHCP, STCP, OE, busy, done
    );

endinterface

// File: rtl/led_panel_sequencer_pwm.sv
// Free-running 8-bit PWM driving the active-low OE; 1-cycle registered output.
// No backpressure; brightness is only adopted at the 255->0 wrap.
module led_pwm_gen
    import led_panel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] brightness,
    output logic             oe
);

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] active_brightness;
    logic [PWM_W-1:0] cnt_nxt;
    logic [PWM_W-1:0] act_nxt;

    always_comb begin
        cnt_nxt = cnt + 1'b1;
        act_nxt = active_brightness;
        if (cnt == {PWM_W{1'b1}}) begin
            act_nxt = brightness;
        end
    end

    // OE is registered from next-cycle values so it lines up with the counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt               <= '0;
            active_brightness <= '0;
            oe                <= 1'b1;
        end else begin
            cnt               <= cnt_nxt;
            active_brightness <= act_nxt;
            oe                <= !(cnt_nxt < act_nxt);
        end
    end

endmodule

// File: rtl/led_panel_sequencer.sv
// Serialises a 32-bit frame MSB-first into a 74HC595-style chain, then latches it.
// Latency: handshake to done = 66*CLK_DIV cycles; frame_ready low while busy.
module led_panel_sequencer
    import led_panel_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    led_panel_sequencer_if.slave bus
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    seq_state_t         state;
    logic [FRAME_W-1:0] shreg;
    logic [4:0]         bit_idx;
    logic [7:0]         div_cnt;
    logic               ds_q;
    logic               shcp_q;
    logic               stcp_q;
    logic               done_q;
    logic               busy_q;
    logic               ready_q;
    logic               oe_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            div_cnt <= '0;
            ds_q    <= 1'b0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    ds_q    <= 1'b0;
                    shcp_q  <= 1'b0;
                    stcp_q  <= 1'b0;
                    div_cnt <= '0;
                    if (bus.frame_valid && ready_q) begin
                        shreg   <= bus.frame_data;
                        bit_idx <= 5'd31;
                        ds_q    <= bus.frame_data[FRAME_W-1];
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        shcp_q  <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        shcp_q  <= 1'b0;
                        // DS only moves together with the SHCP falling edge.
                        if (bit_idx == 5'd0) begin
                            ds_q   <= 1'b0;
                            stcp_q <= 1'b1;
                            state  <= LATCH_HI;
                        end else begin
                            bit_idx <= bit_idx - 5'd1;
                            shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                            ds_q    <= shreg[FRAME_W-2];
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                LATCH_HI: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        stcp_q  <= 1'b0;
                        done_q  <= (CLK_DIV == 1);
                        state   <= LATCH_LO;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                LATCH_LO: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                        // Raise done so it occupies exactly the last LATCH_LO cycle.
                        done_q  <= (CLK_DIV > 1) && (div_cnt == DIV_LAST - 8'd1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    led_pwm_gen u_pwm (
        .clk        (clk),
        .rst        (rst),
        .brightness (bus.brightness),
        .oe         (oe_q)
    );

    assign bus.DS          = ds_q;
    assign bus.SHCP        = shcp_q;
    assign bus.STCP        = stcp_q;
    assign bus.OE          = oe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.frame_ready = ready_q;

endmodule

// File: tb/tb_led_panel_sequencer.sv
// Directed bench for led_panel_sequencer with a 32-bit shift/latch chain model.
module tb_led_panel_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    led_panel_sequencer_if bus ();

    led_panel_sequencer #(.CLK_DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Chain model: shift on SHCP rise, latch on STCP rise.
    logic [31:0] chain   = '0;
    logic [31:0] latched = '0;
    int shcp_rises = 0;
    int stcp_rises = 0;
    int overlap    = 0;
    int ds_viol    = 0;
    logic p_shcp = 1'b0;
    logic p_stcp = 1'b0;
    logic p_ds   = 1'b0;

    always @(negedge clk) begin
        if (bus.SHCP && !p_shcp) begin
            chain = {chain[30:0], bus.DS};
            shcp_rises++;
        end
        if (bus.STCP && !p_stcp) begin
            latched = chain;
            stcp_rises++;
        end
        if (bus.SHCP && bus.STCP) overlap++;
        if (bus.SHCP && p_shcp && (bus.DS !== p_ds)) ds_viol++;
        p_shcp = bus.SHCP;
        p_stcp = bus.STCP;
        p_ds   = bus.DS;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits for frame_ready, then lets the handshake edge pass; returns handshake cycle.
    task automatic handshake(input string tag, output int h_cyc);
        int n;
        n = 0;
        while (bus.frame_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_ready_timeout"}, 32'(n < 300), 32'd1);
        h_cyc = cyc;
        tick();
    endtask

    task automatic wait_done(input string tag, output int d_cyc);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_done_timeout"}, 32'(n < 400), 32'd1);
        d_cyc = cyc;
    endtask

    task automatic pwm_lows(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.OE === 1'b0) lows++;
            tick();
        end
    endtask

    initial begin
        int h0, d0, h1, d1, d2, s0, t0, lows, n;
        bus.frame_data  = '0;
        bus.frame_valid = 1'b0;
        bus.brightness  = 8'd0;

        // Reset
        rst = 1'b0;
        tick(); tick(); tick();
        check("rst_oe",    32'(bus.OE),          32'd1);
        check("rst_shcp",  32'(bus.SHCP),        32'd0);
        check("rst_stcp",  32'(bus.STCP),        32'd0);
        check("rst_ds",    32'(bus.DS),          32'd0);
        check("rst_ready", 32'(bus.frame_ready), 32'd0);
        check("rst_busy",  32'(bus.busy),        32'd0);
        check("rst_done",  32'(bus.done),        32'd0);
        rst = 1'b1;
        tick();
        check("rel_ready", 32'(bus.frame_ready), 32'd1);

        // Single frame
        s0 = shcp_rises; t0 = stcp_rises;
        bus.frame_data  = 32'hA5C3_0FF0;
        bus.frame_valid = 1'b1;
        handshake("single", h0);
        bus.frame_valid = 1'b0;
        check("single_busy", 32'(bus.busy), 32'd1);
        wait_done("single", d0);
        check("single_latency", 32'(d0 - h0), 32'd132);
        check("single_shcp_edges", 32'(shcp_rises - s0), 32'd32);
        check("single_stcp_pulses", 32'(stcp_rises - t0), 32'd1);
        check("single_out_D", 32'(latched[31:24]), 32'hA5);
        check("single_out_C", 32'(latched[23:16]), 32'hC3);
        check("single_out_B", 32'(latched[15:8]),  32'h0F);
        check("single_out_A", 32'(latched[7:0]),   32'hF0);
        tick();
        check("single_done_pulse", 32'(bus.done), 32'd0);
        check("single_idle_ready", 32'(bus.frame_ready), 32'd1);

        // Back-to-back
        bus.frame_data  = 32'hFFFF_FFFF;
        bus.frame_valid = 1'b1;
        handshake("b2b1", h1);
        wait_done("b2b1", d1);
        check("b2b1_latched", latched, 32'hFFFF_FFFF);
        bus.frame_data = 32'h0000_0000;
        tick();
        check("b2b_ready_after_done", 32'(bus.frame_ready), 32'd1);
        tick();
        check("b2b_second_accepted", 32'(bus.busy), 32'd1);
        wait_done("b2b2", d2);
        bus.frame_valid = 1'b0;
        check("b2b2_latency", 32'(d2 - (d1 + 1)), 32'd132);
        check("b2b2_latched", latched, 32'h0000_0000);

        // Busy ignore
        bus.frame_data  = 32'h1234_5678;
        bus.frame_valid = 1'b1;
        handshake("busy", h0);
        for (int i = 0; i < 20; i++) tick();
        bus.frame_data = 32'hDEAD_BEEF;
        wait_done("busy", d0);
        bus.frame_valid = 1'b0;
        check("busy_latched", latched, 32'h1234_5678);
        tick(); tick();

        // Reset mid-frame
        s0 = shcp_rises; t0 = stcp_rises;
        bus.frame_data  = 32'hCAFE_F00D;
        bus.frame_valid = 1'b1;
        handshake("midrst", h0);
        bus.frame_valid = 1'b0;
        n = 0;
        while ((shcp_rises - s0) < 10 && n < 200) begin
            tick();
            n++;
        end
        check("midrst_bits_timeout", 32'(n < 200), 32'd1);
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        tick();
        check("midrst_no_stcp", 32'(stcp_rises - t0), 32'd0);
        check("midrst_retained", latched, 32'h1234_5678);
        check("midrst_ready", 32'(bus.frame_ready), 32'd1);
        bus.frame_data  = 32'h8001_7FFE;
        bus.frame_valid = 1'b1;
        handshake("after", h0);
        bus.frame_valid = 1'b0;
        wait_done("after", d0);
        check("after_latency", 32'(d0 - h0), 32'd132);
        check("after_latched", latched, 32'h8001_7FFE);
        check("no_overlap", 32'(overlap), 32'd0);
        check("ds_stable_hi", 32'(ds_viol), 32'd0);

        // PWM
        bus.brightness = 8'd64;
        n = 0;
        while (bus.OE !== 1'b0 && n < 600) begin
            tick();
            n++;
        end
        check("pwm_sync_timeout", 32'(n < 600), 32'd1);
        pwm_lows(256, lows);
        check("pwm_64", 32'(lows), 32'd64);
        pwm_lows(100, lows);
        check("pwm_64_partial", 32'(lows), 32'd64);
        bus.brightness = 8'd200;
        pwm_lows(156, lows);
        check("pwm_no_midperiod_change", 32'(lows), 32'd0);
        pwm_lows(256, lows);
        check("pwm_200", 32'(lows), 32'd200);
        bus.brightness = 8'd0;
        pwm_lows(256, lows);
        check("pwm_200_held", 32'(lows), 32'd200);
        bus.brightness = 8'd255;
        pwm_lows(256, lows);
        check("pwm_0", 32'(lows), 32'd0);
        pwm_lows(256, lows);
        check("pwm_255", 32'(lows), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
